// File: rtl/rfg_frame_pkg.sv
// rtl/rfg_frame_pkg.sv - shared types and constants for the RFG egress framer
package rfg_frame_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SYNC = 3'd1,
        LEN  = 3'd2,
        PAY  = 3'd3,
        CSUM = 3'd4
    } tx_state_t;

    localparam logic [7:0] RFG_FRAME_SYNC = 8'hA5;

endpackage

// File: rtl/rfg_axis_tx_framer_if.sv
// rtl/rfg_axis_tx_framer_if.sv - byte-wide stream bundle used on both framer ports
interface rfg_axis_tx_framer_if;

    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;
    logic       tlast;

    modport master (output tdata, output tvalid, output tlast, input  tready);
    modport slave  (input  tdata, input  tvalid, input  tlast, output tready);

endinterface

// File: rtl/axis_byte_fifo.sv
// rtl/axis_byte_fifo.sv - synchronous first-word-fall-through byte FIFO for frame payload
module axis_byte_fifo #(
    parameter int DEPTH = 64
) (
    input  logic       aclk,
    input  logic       aresetn,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en && !full)  wr_ptr <= wr_ptr + 1'b1;
            if (rd_en && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (wr_en && !full) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/rfg_axis_tx_framer.sv
// rtl/rfg_axis_tx_framer.sv - wraps protocol-engine response bytes into SYNC/LEN/payload/CSUM frames
module rfg_axis_tx_framer
    import rfg_frame_pkg::*;
#(
    parameter int         MAX_LEN   = 32,
    parameter int         DEPTH     = 64,
    parameter int         TIMEOUT   = 255,
    parameter logic [7:0] SYNC_BYTE = RFG_FRAME_SYNC
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    rfg_axis_tx_framer_if.slave         s_axis,
    rfg_axis_tx_framer_if.master        m_axis,
    output logic [15:0]                 frame_count
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    tx_state_t     state_q, state_d;
    logic [7:0]    pending_q;
    logic [7:0]    len_q;
    logic [7:0]    csum_q;
    logic [7:0]    pay_cnt_q;
    logic [TW-1:0] timer_q;
    logic          close_req_q;
    logic          run_q;

    logic          buf_full, buf_empty;
    logic [7:0]    buf_rdata;
    logic          in_hs, out_hs, do_close, pop, timeout_hit, close_set;

    // run_q keeps ingress closed while reset is held and for the first cycle after release.
    assign s_axis.tready = run_q && !close_req_q && (pending_q < 8'(MAX_LEN)) && !buf_full;

    assign in_hs       = s_axis.tvalid && s_axis.tready;
    assign out_hs      = m_axis.tvalid && m_axis.tready;
    assign do_close    = (state_q == IDLE) && close_req_q;
    assign pop         = (state_q == PAY) && out_hs;
    assign timeout_hit = (TIMEOUT != 0) && (pending_q != 8'd0) && (timer_q == TW'(TIMEOUT));
    assign close_set   = (in_hs && (s_axis.tlast || (pending_q == 8'(MAX_LEN - 1)))) || timeout_hit;

    axis_byte_fifo #(.DEPTH(DEPTH)) u_payload_fifo (
        .aclk    (aclk),
        .aresetn (aresetn),
        .wr_en   (in_hs),
        .wr_data (s_axis.tdata),
        .rd_en   (pop),
        .rd_data (buf_rdata),
        .full    (buf_full),
        .empty   (buf_empty)
    );

    // Ingress accounting: pending bytes, idle timer and the close request.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            run_q       <= 1'b0;
            pending_q   <= 8'd0;
            len_q       <= 8'd0;
            timer_q     <= '0;
            close_req_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
            if (do_close) begin
                len_q       <= pending_q;
                pending_q   <= 8'd0;
                close_req_q <= 1'b0;
                timer_q     <= '0;
            end else begin
                if (in_hs)     pending_q   <= pending_q + 8'd1;
                if (close_set) close_req_q <= 1'b1;
                if (in_hs)
                    timer_q <= '0;
                else if ((pending_q != 8'd0) && (timer_q != TW'(TIMEOUT)))
                    timer_q <= timer_q + 1'b1;
            end
        end
    end

    // Egress datapath: checksum seeded with LEN, payload down-counter, frame counter.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            csum_q      <= 8'd0;
            pay_cnt_q   <= 8'd0;
            frame_count <= 16'd0;
        end else begin
            if (do_close)
                csum_q <= pending_q;
            else if (pop)
                csum_q <= csum_q ^ buf_rdata;

            if ((state_q == LEN) && out_hs)
                pay_cnt_q <= len_q;
            else if (pop)
                pay_cnt_q <= pay_cnt_q - 8'd1;

            if ((state_q == CSUM) && out_hs)
                frame_count <= frame_count + 16'd1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (do_close) state_d = SYNC;
            SYNC:    if (out_hs) state_d = LEN;
            LEN:     if (out_hs) state_d = PAY;
            PAY:     if (pop && (pay_cnt_q == 8'd1)) state_d = CSUM;
            CSUM:    if (out_hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        m_axis.tvalid = 1'b0;
        m_axis.tdata  = 8'd0;
        m_axis.tlast  = 1'b0;
        case (state_q)
            SYNC: begin
                m_axis.tvalid = 1'b1;
                m_axis.tdata  = SYNC_BYTE;
            end
            LEN: begin
                m_axis.tvalid = 1'b1;
                m_axis.tdata  = len_q;
            end
            PAY: begin
                m_axis.tvalid = !buf_empty;
                m_axis.tdata  = buf_rdata;
            end
            CSUM: begin
                m_axis.tvalid = 1'b1;
                m_axis.tdata  = csum_q;
                m_axis.tlast  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rfg_axis_tx_framer.sv
// tb/tb_rfg_axis_tx_framer.sv - scoreboard bench for the RFG egress framer
module tb_rfg_axis_tx_framer;
    import rfg_frame_pkg::*;

    localparam int MAX_LEN = 32;
    localparam int TIMEOUT = 255;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [15:0] frame_count;

    rfg_axis_tx_framer_if s_axis ();
    rfg_axis_tx_framer_if m_axis ();

    rfg_axis_tx_framer #(
        .MAX_LEN   (MAX_LEN),
        .DEPTH     (64),
        .TIMEOUT   (TIMEOUT),
        .SYNC_BYTE (8'hA5)
    ) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .s_axis      (s_axis),
        .m_axis      (m_axis),
        .frame_count (frame_count)
    );

    always #5 aclk = ~aclk;

    int         errors = 0;
    int         checks = 0;
    logic [8:0] exp_q[$];
    logic [7:0] pend_q[$];
    int         exp_frames = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_emit();
        logic [7:0] len;
        logic [7:0] cs;
        len = 8'(pend_q.size());
        cs  = len;
        exp_q.push_back({1'b0, 8'hA5});
        exp_q.push_back({1'b0, len});
        foreach (pend_q[i]) begin
            exp_q.push_back({1'b0, pend_q[i]});
            cs = cs ^ pend_q[i];
        end
        exp_q.push_back({1'b1, cs});
        pend_q.delete();
        exp_frames++;
    endfunction

    function automatic void model_accept(input logic [7:0] d, input logic last);
        pend_q.push_back(d);
        if (last || (pend_q.size() == MAX_LEN)) model_emit();
    endfunction

    function automatic void model_flush();
        if (pend_q.size() != 0) model_emit();
    endfunction

    always @(negedge aclk) begin
        if (aresetn && m_axis.tvalid && m_axis.tready) begin
            if (exp_q.size() == 0) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL spurious_output observed=%0h expected=none", m_axis.tdata);
                end
            end else begin
                check("out_byte", {23'd0, m_axis.tlast, m_axis.tdata}, {23'd0, exp_q.pop_front()});
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [7:0] d, input logic last);
        int n;
        logic ok;
        n = 0;
        s_axis.tdata  = d;
        s_axis.tvalid = 1'b1;
        s_axis.tlast  = last;
        @(negedge aclk);
        while (!s_axis.tready && n < 2000) begin
            @(negedge aclk);
            n++;
        end
        ok = s_axis.tready;
        check("send_accept", {31'd0, ok}, 32'd1);
        @(posedge aclk);
        #1;
        s_axis.tvalid = 1'b0;
        s_axis.tlast  = 1'b0;
        if (ok) model_accept(d, last);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(posedge aclk);
            n++;
        end
        @(posedge aclk);
        #1;
        check("drain_empty", exp_q.size(), 32'd0);
        check("frame_count", {16'd0, frame_count}, exp_frames);
    endtask

    // Called right after the last ingress handshake with the output idle.
    task automatic expect_timeout();
        repeat (TIMEOUT + 1) @(posedge aclk);
        @(negedge aclk);
        check("timeout_quiet", {31'd0, m_axis.tvalid}, 32'd0);
        model_flush();
        @(posedge aclk);
        @(negedge aclk);
        check("timeout_sync_valid", {31'd0, m_axis.tvalid}, 32'd1);
        check("timeout_sync_byte", {24'd0, m_axis.tdata}, 32'hA5);
        drain();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        s_axis.tdata  = 8'd0;
        s_axis.tvalid = 1'b0;
        s_axis.tlast  = 1'b0;
        m_axis.tready = 1'b1;

        repeat (3) @(posedge aclk);
        #1;
        check("rst_tvalid", {31'd0, m_axis.tvalid}, 32'd0);
        check("rst_tdata", {24'd0, m_axis.tdata}, 32'd0);
        check("rst_tlast", {31'd0, m_axis.tlast}, 32'd0);
        check("rst_tready", {31'd0, s_axis.tready}, 32'd0);
        check("rst_frame_count", {16'd0, frame_count}, 32'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        check("post_rst_ready", {31'd0, s_axis.tready}, 32'd1);

        // Short frame closed by tlast
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b1);
        drain();

        // 40 bytes: MAX_LEN frame, then a timeout frame for the tail
        for (int i = 0; i < 40; i++) send(8'(i), 1'b0);
        expect_timeout();

        // Two bytes closed only by the idle timeout
        send(8'h05, 1'b0);
        send(8'h06, 1'b0);
        expect_timeout();

        // Egress backpressure mid-payload, ingress fills to MAX_LEN and stalls
        for (int i = 0; i < 5; i++) send(8'h40 + 8'(i), i == 4);
        repeat (4) @(posedge aclk);
        #1;
        m_axis.tready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge aclk);
            check("hold_tvalid", {31'd0, m_axis.tvalid}, 32'd1);
            check("hold_tdata", {24'd0, m_axis.tdata}, 32'h41);
        end
        @(posedge aclk);
        #1;
        for (int i = 0; i < 32; i++) send(8'h80 + 8'(i), 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            check("ingress_stall", {31'd0, s_axis.tready}, 32'd0);
            check("stall_tdata", {24'd0, m_axis.tdata}, 32'h41);
        end
        @(posedge aclk);
        #1;
        m_axis.tready = 1'b1;
        drain();

        // Reset during payload of a 16-byte frame
        for (int i = 0; i < 16; i++) send(8'h60 + 8'(i), i == 15);
        repeat (6) @(posedge aclk);
        #1;
        aresetn = 1'b0;
        #1;
        check("midrst_tvalid", {31'd0, m_axis.tvalid}, 32'd0);
        check("midrst_frame_count", {16'd0, frame_count}, 32'd0);
        check("midrst_tready", {31'd0, s_axis.tready}, 32'd0);
        exp_q.delete();
        pend_q.delete();
        exp_frames = 0;
        @(negedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        check("post_midrst_ready", {31'd0, s_axis.tready}, 32'd1);
        send(8'h71, 1'b0);
        send(8'h72, 1'b0);
        send(8'h73, 1'b1);
        drain();

        // tlast together with MAX_LEN closes exactly one frame
        for (int i = 0; i < 32; i++) send(8'hC0 + 8'(i), i == 31);
        drain();
        repeat (TIMEOUT + 20) @(posedge aclk);
        #1;
        check("no_empty_frame", {16'd0, frame_count}, exp_frames);
        check("no_empty_tvalid", {31'd0, m_axis.tvalid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
